regfile_nw_shadow: RTL and testbench
====================================

Name: regfile_nw_shadow

Overview:
- Parametrised multi-port register file for the FPU/integer datapath.
- Generalises the fixed 2-read/2-write 32x32 file to N read ports, M write ports, configurable width and depth.
- Adds optional write-to-read bypass, optional hardwired zero register, and a single-cycle shadow bank for interrupt context save/restore.
- Sits between decode (read addresses) and writeback (write ports); the interrupt controller drives save/restore.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- rn  in  NRD*ADDR_W  read addresses; port r = bits [r*ADDR_W +: ADDR_W]
- q  out  NRD*DATA_W  read data; port r = bits [r*DATA_W +: DATA_W]
- wn  in  NWR*ADDR_W  write addresses, packed as rn
- d  in  NWR*DATA_W  write data, packed as q
- we  in  NWR  per-port write enables
- save  in  1  copy architectural state into shadow bank
- restore  in  1  copy shadow bank into architectural state
- shadow_valid  out  1  shadow bank holds an unrestored snapshot
- err  out  1  one-cycle pulse: restore requested with no valid snapshot
- wdrop  out  1  one-cycle pulse: at least one write discarded by an accepted restore

Behaviour:
- One clock `clk`; reset `clr` is synchronous and active-high. Asserting `clr` at a rising edge zeroes:
  - every register
  - every shadow entry
  - `shadow_valid`, `err`, `wdrop`
- `clr` overrides save, restore and writes in that cycle. Reset mid-snapshot loses the snapshot.
- Reads are combinational, zero latency:
  - `q[r]` = `array[rn[r]]`.
  - ZERO_REG=1: address 0 reads 0 regardless of array or bypass.
- Writes land at the rising edge. Same-address conflict: the highest-index enabled port wins; lower ports to that address are suppressed.
- ZERO_REG=1: writes to address 0 are discarded; `wdrop` is not raised.
- Bypass (BYPASS=1):
  - If any enabled write port matches `rn[r]`, `q[r]` = `d` of the highest-index such port.
  - Bypass is disabled in a cycle where restore is accepted, and for address 0 when ZERO_REG=1.
- BYPASS=0: `q` reflects only committed state; write data is visible from the next cycle.
- Restore is accepted when `restore`=1 and `shadow_valid`=1. Then:
  - array <= shadow
  - all writes that cycle are discarded
  - `wdrop` = 1 next cycle if any `we` bit was set
  - `shadow_valid` <= 0
- Restore with `shadow_valid`=0 is ignored: writes proceed normally, `err` = 1 next cycle.
- Save (without an accepted restore):
  - shadow <= post-write array, i.e. this cycle's writes are included in the snapshot
  - `shadow_valid` <= 1
  - A second save overwrites the snapshot.
- Save and restore in the same cycle:
  - If restore is accepted: swap. array <= old shadow, shadow <= pre-write array, writes discarded, `shadow_valid` stays 1.
  - If restore is not accepted: behaves as a plain save, and `err` pulses.
- `err` and `wdrop` are registered, held high for exactly one cycle, and low otherwise.

Decomposition:
- Package `regfile_pkg`:
  - default width/depth constants
  - helper function `rf_wsel` returning the winning write-port index and hit flag for an address
- Sub-module `regfile_bypass`:
  - one instance per read port
  - inputs: `rn[r]`, `wn`, `d`, `we`, array word, bypass-enable, zero-reg flag
  - output: `q[r]`
- Top level holds the array, shadow, flags and save/restore sequencing.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert `clr` -> next cycle `q`(rn=5)=0, `shadow_valid`=0, `err`=0.
- Write conflict: port0 wn=3 d=0x11, port1 wn=3 d=0x22 same cycle -> r3=0x22; BYPASS=1 read of r3 that cycle = 0x22.
- ZERO_REG=1: write 0x55 to r0 on port1 -> `q`(rn=0)=0 same and next cycle; `wdrop`=0.
- Save includes writes: r7=0x01, then save with a concurrent write r7=0x02, then write r7=0x03, then restore -> r7=0x02, `shadow_valid`=0.
- Restore drops writes: after a save, restore while writing r9=0xAA -> r9 = snapshot value, `wdrop`=1 for one cycle, same-cycle read of r9 not bypassed.
- Error and swap:
  - restore with `shadow_valid`=0 -> `err`=1 for one cycle, writes land.
  - with a valid snapshot, save+restore together (r1=0x10 live, 0x20 shadowed) -> r1=0x20, shadow r1=0x10, `shadow_valid`=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the write-port selection helper for the multi-port
// register file with a shadow bank.
package regfile_pkg;

   localparam int RF_DATA_W     = 32;
   localparam int RF_ADDR_W     = 5;
   localparam int RF_DEPTH      = 1 << RF_ADDR_W;

   // The selection helper works on fixed-size vectors so it can serve every
   // instance of the file. Instances are limited to RF_MAX_NWR write ports
   // and RF_MAX_ADDR_W address bits.
   localparam int RF_MAX_NWR    = 8;
   localparam int RF_MAX_ADDR_W = 8;
   localparam int RF_WIDX_W     = $clog2(RF_MAX_NWR);

   // Result of a write-port search for one address: whether any enabled port
   // targets it and, if so, which port wins.
   typedef struct packed {
      logic                 hit;
      logic [RF_WIDX_W-1:0] idx;
   } rf_wsel_t;

   // Scans the write ports in ascending order, so the highest-index enabled
   // port that matches addr is the one reported. Unused upper ports must be
   // presented with their enable bit cleared.
   function automatic rf_wsel_t rf_wsel(
      input logic [RF_MAX_ADDR_W-1:0]            addr,
      input logic [RF_MAX_NWR*RF_MAX_ADDR_W-1:0] wn,
      input logic [RF_MAX_NWR-1:0]               we
   );
      rf_wsel_t sel;
      sel.hit = 1'b0;
      sel.idx = '0;
      for (int i = 0; i < RF_MAX_NWR; i++) begin
         if (we[i] && (wn[i*RF_MAX_ADDR_W +: RF_MAX_ADDR_W] == addr)) begin
            sel.hit = 1'b1;
            sel.idx = RF_WIDX_W'(i);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Read-port output stage: picks between the committed array word, same-cycle
// write data, and a forced zero for register 0.
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NWR    = 2
) (
   input  logic [ADDR_W-1:0]     rn,
   input  logic [NWR*ADDR_W-1:0] wn,
   input  logic [NWR*DATA_W-1:0] d,
   input  logic [NWR-1:0]        we,
   input  logic [DATA_W-1:0]     word,
   input  logic                  byp_en,
   input  logic                  zero_en,
   output logic [DATA_W-1:0]     q
);

   logic [RF_MAX_ADDR_W-1:0]            addr_ext;
   logic [RF_MAX_NWR*RF_MAX_ADDR_W-1:0] wn_ext;
   logic [RF_MAX_NWR-1:0]               we_ext;
   rf_wsel_t                            sel;

   // Widen the address and write-port vectors to the helper's fixed shape;
   // unused ports keep a zero enable so they can never match.
   always_comb begin
      addr_ext             = '0;
      addr_ext[ADDR_W-1:0] = rn;
      wn_ext               = '0;
      we_ext               = '0;
      for (int i = 0; i < NWR; i++) begin
         wn_ext[i*RF_MAX_ADDR_W +: ADDR_W] = wn[i*ADDR_W +: ADDR_W];
         we_ext[i]                         = we[i];
      end
      sel = rf_wsel(addr_ext, wn_ext, we_ext);
   end

   // Zero register takes priority over everything, then forwarding of the
   // winning write port, otherwise the committed word.
   always_comb begin
      q = word;
      if (byp_en && sel.hit) begin
         for (int i = 0; i < NWR; i++) begin
            if (sel.idx == RF_WIDX_W'(i)) begin
               q = d[i*DATA_W +: DATA_W];
            end
         end
      end
      if (zero_en && (rn == '0)) begin
         q = '0;
      end
   end

endmodule

// File: rtl/regfile_nw_shadow.sv
// Parametrised N-read / M-write register file with optional bypass, optional
// hardwired zero register and a single-cycle shadow bank used by the
// interrupt controller for context save and restore.
module regfile_nw_shadow
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [NRD*ADDR_W-1:0] rn,
   output logic [NRD*DATA_W-1:0] q,
   input  logic [NWR*ADDR_W-1:0] wn,
   input  logic [NWR*DATA_W-1:0] d,
   input  logic [NWR-1:0]        we,
   input  logic                  save,
   input  logic                  restore,
   output logic                  shadow_valid,
   output logic                  err,
   output logic                  wdrop
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] rf      [DEPTH];
   logic [DATA_W-1:0] shadow  [DEPTH];
   logic [DATA_W-1:0] rf_post [DEPTH];
   logic [DATA_W-1:0] rd_word [NRD];

   logic [RF_MAX_NWR*RF_MAX_ADDR_W-1:0] wn_ext;
   logic [RF_MAX_NWR-1:0]               we_ext;

   logic shadow_valid_q;
   logic err_q;
   logic wdrop_q;
   logic restore_ok;
   logic byp_en;
   logic zero_en;

   assign zero_en    = (ZERO_REG != 0);
   assign restore_ok = restore && shadow_valid_q;

   // Forwarding is suppressed in a restore cycle because those writes never
   // land, so forwarding them would show data that does not exist.
   assign byp_en     = (BYPASS != 0) && !restore_ok;

   assign shadow_valid = shadow_valid_q;
   assign err          = err_q;
   assign wdrop        = wdrop_q;

   // Widen the write ports once to the helper's fixed shape for the per-entry
   // write decode below.
   always_comb begin
      wn_ext = '0;
      we_ext = '0;
      for (int i = 0; i < NWR; i++) begin
         wn_ext[i*RF_MAX_ADDR_W +: ADDR_W] = wn[i*ADDR_W +: ADDR_W];
         we_ext[i]                         = we[i];
      end
   end

   // Post-write image of the array: what each entry becomes if this cycle's
   // writes are allowed to commit. It feeds both the array update and a plain
   // save, so a save captures the writes that happen alongside it.
   always_comb begin
      rf_wsel_t sel;
      sel = '0;
      for (int a = 0; a < DEPTH; a++) begin
         rf_post[a] = rf[a];
         sel        = rf_wsel(RF_MAX_ADDR_W'(a), wn_ext, we_ext);
         if (sel.hit && !(zero_en && (a == 0))) begin
            for (int i = 0; i < NWR; i++) begin
               if (sel.idx == RF_WIDX_W'(i)) begin
                  rf_post[a] = d[i*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   // Committed array words for each read port, before forwarding and the
   // zero-register override are applied.
   always_comb begin
      for (int r = 0; r < NRD; r++) begin
         rd_word[r] = rf[rn[r*ADDR_W +: ADDR_W]];
      end
   end

   for (genvar r = 0; r < NRD; r++) begin : g_rd
      regfile_bypass #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NWR    (NWR)
      ) u_bypass (
         .rn      (rn[r*ADDR_W +: ADDR_W]),
         .wn      (wn),
         .d       (d),
         .we      (we),
         .word    (rd_word[r]),
         .byp_en  (byp_en),
         .zero_en (zero_en),
         .q       (q[r*DATA_W +: DATA_W])
      );
   end

   // State update. An accepted restore reloads the array from the shadow and
   // throws away this cycle's writes; combined with save it becomes a swap in
   // which the shadow takes the pre-write array and stays valid. Without an
   // accepted restore the writes commit and a save snapshots the result.
   // The error and drop flags are recomputed every cycle, so they only ever
   // stay high for the one cycle after their cause.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int a = 0; a < DEPTH; a++) begin
            rf[a]     <= '0;
            shadow[a] <= '0;
         end
         shadow_valid_q <= 1'b0;
         err_q          <= 1'b0;
         wdrop_q        <= 1'b0;
      end else begin
         err_q   <= restore && !shadow_valid_q;
         wdrop_q <= restore_ok && (|we);
         if (restore_ok) begin
            for (int a = 0; a < DEPTH; a++) begin
               rf[a] <= shadow[a];
            end
            if (save) begin
               for (int a = 0; a < DEPTH; a++) begin
                  shadow[a] <= rf[a];
               end
            end else begin
               shadow_valid_q <= 1'b0;
            end
         end else begin
            for (int a = 0; a < DEPTH; a++) begin
               rf[a] <= rf_post[a];
            end
            if (save) begin
               for (int a = 0; a < DEPTH; a++) begin
                  shadow[a] <= rf_post[a];
               end
               shadow_valid_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_nw_shadow.sv
// Directed self-checking bench for the shadow-bank register file. Two copies
// share every input: one with default parameters and one with the hardwired
// zero register enabled.
module tb_regfile_nw_shadow;

   logic        clk;
   logic        clr;
   logic [9:0]  rn;
   logic [9:0]  wn;
   logic [63:0] d;
   logic [1:0]  we;
   logic        save;
   logic        restore;

   logic [63:0] q0;
   logic        sv0;
   logic        err0;
   logic        wdrop0;

   logic [63:0] qz;
   logic        svz;
   logic        errz;
   logic        wdropz;

   int checkCount;
   int passCount;

   regfile_nw_shadow #(
      .DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_REG(0), .BYPASS(1)
   ) dut (
      .clk(clk), .clr(clr), .rn(rn), .q(q0), .wn(wn), .d(d), .we(we),
      .save(save), .restore(restore), .shadow_valid(sv0), .err(err0), .wdrop(wdrop0)
   );

   regfile_nw_shadow #(
      .DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)
   ) dutz (
      .clk(clk), .clr(clr), .rn(rn), .q(qz), .wn(wn), .d(d), .we(we),
      .save(save), .restore(restore), .shadow_valid(svz), .err(errz), .wdrop(wdropz)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checkCount++;
      if (got === want) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
      end
   endtask

   // Drive one cycle's worth of inputs and let the combinational reads settle.
   task automatic applyStimulus(
      input logic w0, input logic [4:0] a0, input logic [31:0] v0,
      input logic w1, input logic [4:0] a1, input logic [31:0] v1,
      input logic [4:0] r0, input logic [4:0] r1,
      input logic sv, input logic rs
   );
      we      = {w1, w0};
      wn      = {a1, a0};
      d       = {v1, v0};
      rn      = {r1, r0};
      save    = sv;
      restore = rs;
      #1;
   endtask

   task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, r0, r1, 1'b0, 1'b0);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      clr        = 1'b1;
      idle(5'd0, 5'd0);
      tick;
      tick;
      clr = 1'b0;

      // Reset clears a written register and beats a concurrent write and save
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0);
      tick;
      idle(5'd5, 5'd0);
      checkOutput("r5_written", q0[31:0], 32'hDEADBEEF);
      clr = 1'b1;
      applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0);
      tick;
      clr = 1'b0;
      idle(5'd5, 5'd0);
      checkOutput("rst_r5", q0[31:0], 32'h0);
      checkOutput("rst_sv", {31'b0, sv0}, 32'h0);
      checkOutput("rst_err", {31'b0, err0}, 32'h0);
      checkOutput("rst_wdrop", {31'b0, wdrop0}, 32'h0);
      checkOutput("rst_z_r5", qz[31:0], 32'h0);

      // Same-address write conflict: port 1 wins, also on the bypass path
      applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd4, 1'b0, 1'b0);
      checkOutput("conf_byp", q0[31:0], 32'h22);
      checkOutput("conf_other", q0[63:32], 32'h0);
      tick;
      idle(5'd3, 5'd4);
      checkOutput("conf_r3", q0[31:0], 32'h22);

      // Zero register: write to r0 is dropped silently in the ZERO_REG copy
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd3, 1'b0, 1'b0);
      checkOutput("z_r0_same", qz[31:0], 32'h0);
      checkOutput("nz_r0_byp", q0[31:0], 32'h55);
      checkOutput("z_r3", qz[63:32], 32'h22);
      tick;
      idle(5'd0, 5'd0);
      checkOutput("z_r0_next", qz[31:0], 32'h0);
      checkOutput("z_wdrop", {31'b0, wdropz}, 32'h0);
      checkOutput("nz_r0_next", q0[31:0], 32'h55);

      // Save includes the concurrent write
      applyStimulus(1'b1, 5'd7, 32'h01, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 1'b0);
      tick;
      applyStimulus(1'b1, 5'd7, 32'h02, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b0);
      checkOutput("save_byp", q0[31:0], 32'h02);
      tick;
      applyStimulus(1'b1, 5'd7, 32'h03, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 1'b0);
      checkOutput("save_sv", {31'b0, sv0}, 32'h1);
      tick;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 1'b1);
      checkOutput("pre_rest_r7", q0[31:0], 32'h03);
      tick;
      idle(5'd7, 5'd0);
      checkOutput("rest_r7", q0[31:0], 32'h02);
      checkOutput("rest_sv", {31'b0, sv0}, 32'h0);
      checkOutput("rest_wdrop0", {31'b0, wdrop0}, 32'h0);
      checkOutput("rest_err0", {31'b0, err0}, 32'h0);

      // Restore discards same-cycle writes and does not forward them
      applyStimulus(1'b1, 5'd9, 32'h5A, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 1'b0);
      tick;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 1'b0);
      tick;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd0, 1'b0, 1'b1);
      checkOutput("drop_nobyp", q0[31:0], 32'h5A);
      tick;
      idle(5'd9, 5'd0);
      checkOutput("drop_r9", q0[31:0], 32'h5A);
      checkOutput("drop_wdrop", {31'b0, wdrop0}, 32'h1);
      checkOutput("drop_wdrop_z", {31'b0, wdropz}, 32'h1);
      checkOutput("drop_sv", {31'b0, sv0}, 32'h0);
      tick;
      checkOutput("drop_wdrop_clr", {31'b0, wdrop0}, 32'h0);

      // Restore without a snapshot flags an error and lets writes through
      applyStimulus(1'b1, 5'd10, 32'h77, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0, 1'b0, 1'b1);
      checkOutput("err_byp", q0[31:0], 32'h77);
      tick;
      idle(5'd10, 5'd0);
      checkOutput("err_pulse", {31'b0, err0}, 32'h1);
      checkOutput("err_r10", q0[31:0], 32'h77);
      checkOutput("err_wdrop", {31'b0, wdrop0}, 32'h0);
      tick;
      checkOutput("err_clr", {31'b0, err0}, 32'h0);

      // Save plus accepted restore swaps the live and shadow copies
      applyStimulus(1'b1, 5'd1, 32'h20, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b0, 1'b0);
      tick;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b1, 1'b0);
      tick;
      applyStimulus(1'b1, 5'd1, 32'h10, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b0, 1'b0);
      tick;
      applyStimulus(1'b1, 5'd1, 32'h99, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b1, 1'b1);
      checkOutput("swap_nobyp", q0[31:0], 32'h10);
      tick;
      idle(5'd1, 5'd0);
      checkOutput("swap_r1", q0[31:0], 32'h20);
      checkOutput("swap_sv", {31'b0, sv0}, 32'h1);
      checkOutput("swap_wdrop", {31'b0, wdrop0}, 32'h1);
      checkOutput("swap_err", {31'b0, err0}, 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b0, 1'b1);
      tick;
      idle(5'd1, 5'd0);
      checkOutput("swap_shadow_r1", q0[31:0], 32'h10);
      checkOutput("swap_sv_clr", {31'b0, sv0}, 32'h0);

      // Save plus rejected restore acts as a plain save and flags an error
      applyStimulus(1'b1, 5'd12, 32'h33, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 1'b1, 1'b1);
      checkOutput("svrj_byp", q0[31:0], 32'h33);
      tick;
      idle(5'd12, 5'd0);
      checkOutput("svrj_err", {31'b0, err0}, 32'h1);
      checkOutput("svrj_sv", {31'b0, sv0}, 32'h1);
      checkOutput("svrj_r12", q0[31:0], 32'h33);
      applyStimulus(1'b1, 5'd12, 32'h44, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 1'b0, 1'b0);
      tick;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 1'b0, 1'b1);
      checkOutput("svrj_pre", q0[31:0], 32'h44);
      tick;
      idle(5'd12, 5'd0);
      checkOutput("svrj_rest_r12", q0[31:0], 32'h33);
      checkOutput("svrj_rest_sv", {31'b0, sv0}, 32'h0);
      checkOutput("svrj_rest_err", {31'b0, err0}, 32'h0);
      checkOutput("svrj_z_sv", {31'b0, svz}, 32'h0);
      checkOutput("svrj_z_err", {31'b0, errz}, 32'h0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
